alu_seq: RTL

- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds ready/valid handshakes on both sides, a registered result, and new ops: NOR, SLTU, shifts and a multi-cycle iterative multiply with low/high product select.
- Sits in the EX stage of the pipelined CPU; the hazard unit stalls on in_ready_o/out_valid_o.

---
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with ready/valid handshakes on both sides.
// Single-cycle ops (AND/OR/NOR/ADD/SUB/SLT/SLTU/SLL/SRL/SRA) produce a result
// one edge after accept; MULLO/MULHI run a radix-2 shift-add multiply for
// exactly WIDTH cycles before presenting the selected product half.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   in_valid_i   request valid
//   in_ready_o   request can be accepted this cycle (combinational)
//   src1_i       operand A (two's complement), also the shift source
//   src2_i       operand B; shift amount is src2_i[SHW-1:0]
//   ctrl_i       4-bit opcode
//   out_valid_o  result registers hold a valid result
//   out_ready_i  consumer takes the result
//   result_o     registered result
//   zero_o       registered src1_i == src2_i, captured at accept
//   ovf_o        registered signed overflow (ADD/SUB only)
//   err_o        registered undefined-opcode flag
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned AW  = 2 * WIDTH;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULLO = 4'b1001;
  localparam logic [3:0] OP_MULHI = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               hi_sel_q, hi_sel_d;

  logic               accept_c;
  logic [SHW-1:0]     shamt_c;
  logic [WIDTH-1:0]   sum_c;
  logic [WIDTH-1:0]   diff_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_ovf_c;
  logic               alu_err_c;
  logic               is_mul_c;
  logic [WIDTH:0]     step_sum_c;
  logic [AW-1:0]      acc_step_c;

  assign in_ready_o  = (state_q == IDLE) && (!out_valid_q || out_ready_i);
  assign accept_c    = in_valid_i && in_ready_o;
  assign shamt_c     = src2_i[SHW-1:0];
  assign sum_c       = src1_i + src2_i;
  assign diff_c      = src1_i - src2_i;
  assign is_mul_c    = (ctrl_i == OP_MULLO) || (ctrl_i == OP_MULHI);

  // One shift-add step: conditionally add multiplicand into the upper half,
  // then shift the whole accumulator right; the carry lands in the MSB.
  assign step_sum_c  = {1'b0, acc_q[AW-1:WIDTH]} +
                       {1'b0, mcand_q & {WIDTH{acc_q[0]}}};
  assign acc_step_c  = {step_sum_c, acc_q[WIDTH-1:1]};

  // Single-cycle datapath
  always_comb begin
    alu_res_c = '1;
    alu_ovf_c = 1'b0;
    alu_err_c = 1'b0;
    unique case (ctrl_i)
      OP_AND:  alu_res_c = src1_i & src2_i;
      OP_OR:   alu_res_c = src1_i | src2_i;
      OP_NOR:  alu_res_c = ~(src1_i | src2_i);
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                    (sum_c[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                    (diff_c[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT:  alu_res_c = WIDTH'($signed(src1_i) < $signed(src2_i));
      OP_SLTU: alu_res_c = WIDTH'(src1_i < src2_i);
      OP_SLL:  alu_res_c = src1_i << shamt_c;
      OP_SRL:  alu_res_c = src1_i >> shamt_c;
      OP_SRA:  alu_res_c = WIDTH'($signed(src1_i) >>> shamt_c);
      default: begin
        alu_res_c = '1;
        alu_err_c = 1'b1;
      end
    endcase
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready_i;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    hi_sel_d    = hi_sel_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          zero_d = (src1_i == src2_i);
          if (is_mul_c) begin
            state_d     = MUL;
            out_valid_d = 1'b0;
            acc_d       = {{WIDTH{1'b0}}, src2_i};
            mcand_d     = src1_i;
            cnt_d       = '0;
            hi_sel_d    = (ctrl_i == OP_MULHI);
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res_c;
            ovf_d       = alu_ovf_c;
            err_d       = alu_err_c;
          end
        end
      end
      MUL: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          result_d    = hi_sel_q ? acc_step_c[AW-1:WIDTH] : acc_step_c[WIDTH-1:0];
          ovf_d       = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      hi_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
      hi_sel_q    <= hi_sel_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign ovf_o       = ovf_q;
  assign err_o       = err_q;

endmodule
